// File: rtl/core_pkg.sv
// Shared core definitions: hazard FSM states, forward selects, PC index.
package core_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } hazard_state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam int PC_REG = 15;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign count = cnt_q;

endmodule

// File: rtl/hazard_controller.sv
// Hazard unit: operand forwarding, load-use/branch stall and flush,
// memory-wait freeze with timeout, and saturating debug counters.
import core_pkg::*;

module hazard_controller #(
  parameter int REG_W       = 4,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] RA1D,
  input  logic [REG_W-1:0] RA2D,
  input  logic [REG_W-1:0] RA1E,
  input  logic [REG_W-1:0] RA2E,
  input  logic [REG_W-1:0] WA3E,
  input  logic [REG_W-1:0] WA3M,
  input  logic [REG_W-1:0] WA3W,
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemtoRegE,
  input  logic             BranchTakenE,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             MemErr,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  localparam int TW = $clog2(MEM_TIMEOUT + 1);

  hazard_state_t state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;

  logic ldstall;
  logic memstall;

  function automatic logic [1:0] fwd_sel(
    input logic [REG_W-1:0] ra
  );
    logic pc;
    pc = (ra == REG_W'(PC_REG));
    if (RegWriteM && (WA3M == ra) && !pc) begin
      return FWD_MEM;
    end else if (RegWriteW && (WA3W == ra) && !pc) begin
      return FWD_WB;
    end
    return FWD_RF;
  endfunction

  assign ldstall = MemtoRegE && RegWriteE &&
                   ((WA3E == RA1D) || (WA3E == RA2D));

  assign memstall = (state_q == MEM_WAIT) ||
                    ((state_q == RUN) && MemReqM && !MemReadyM);

  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      RUN: begin
        if (MemReqM && !MemReadyM) begin
          state_d = MEM_WAIT;
          tmo_d   = TW'(1);
        end
      end
      MEM_WAIT: begin
        if (MemReadyM) begin
          state_d = RUN;
          tmo_d   = '0;
        end else if (tmo_q == TW'(MEM_TIMEOUT)) begin
          state_d = ERROR;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ERROR: begin
        state_d = ERROR;
      end
      default: begin
        state_d = RUN;
        tmo_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
    end
  end

  // Freeze suppresses D/E flushes so branch/load-use is replayed on release
  always_comb begin
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushW    = 1'b0;
    MemErr    = 1'b0;
    if (!rst) begin
      ForwardAE = fwd_sel(RA1E);
      ForwardBE = fwd_sel(RA2E);
      unique case (1'b1)
        (state_q == ERROR): begin
          MemErr = 1'b1;
          StallF = 1'b1;
          StallD = 1'b1;
          StallE = 1'b1;
          StallM = 1'b1;
        end
        memstall: begin
          StallF = 1'b1;
          StallD = 1'b1;
          StallE = 1'b1;
          StallM = 1'b1;
          FlushW = 1'b1;
        end
        default: begin
          StallF = ldstall;
          StallD = ldstall;
          FlushD = BranchTakenE;
          FlushE = BranchTakenE || ldstall;
        end
      endcase
    end
  end

  logic stall_any;
  logic flush_any;

  assign stall_any = StallF || StallD || StallE || StallM;
  assign flush_any = FlushD || FlushE;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .en    (stall_any),
    .clr   (rst),
    .count (StallCnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .en    (flush_any),
    .clr   (rst),
    .count (FlushCnt)
  );

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: directed literals plus
// randomized traffic against a behavioural model.
module tb_hazard_controller;

  localparam int RW  = 4;
  localparam int TMO = 4;
  localparam int CW  = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  logic [RW-1:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
  logic RegWriteE, RegWriteM, RegWriteW, MemtoRegE;
  logic BranchTakenE, MemReqM, MemReadyM;
  logic [1:0] ForwardAE, ForwardBE;
  logic StallF, StallD, StallE, StallM;
  logic FlushD, FlushE, FlushW, MemErr;
  logic [CW-1:0] StallCnt, FlushCnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hazard_controller #(
    .REG_W(RW), .MEM_TIMEOUT(TMO), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE),
    .BranchTakenE(BranchTakenE), .MemReqM(MemReqM),
    .MemReadyM(MemReadyM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD),
    .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .MemErr(MemErr), .StallCnt(StallCnt), .FlushCnt(FlushCnt)
  );

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d t=%0t", n, act, exp, $time);
    end
  endtask

  task automatic clear_in();
    RA1D = '0; RA2D = '0; RA1E = '0; RA2E = '0;
    WA3E = '0; WA3M = '0; WA3W = '0;
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
    MemtoRegE = 0; BranchTakenE = 0;
    MemReqM = 0; MemReadyM = 0;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Model: mem-wait progress (0 = not waiting, k = k-th wait cycle),
  // sticky error, and counters.
  int  m_wait = 0;
  bit  m_err  = 0;
  int  m_sc   = 0;
  int  m_fc   = 0;

  function automatic int exp_fwd(logic [RW-1:0] r);
    if (r == 15) return 0;
    if (RegWriteM && WA3M == r) return 2;
    if (RegWriteW && WA3W == r) return 1;
    return 0;
  endfunction

  always @(negedge clk) begin : model
    int fa, fb, sf, sd, se, sm, fd, fe, fw, me;
    bit ld, frz;
    fa = 0; fb = 0; sf = 0; sd = 0; se = 0; sm = 0;
    fd = 0; fe = 0; fw = 0; me = 0;
    if (!rst) begin
      fa = exp_fwd(RA1E);
      fb = exp_fwd(RA2E);
      ld = MemtoRegE && RegWriteE && (WA3E == RA1D || WA3E == RA2D);
      frz = (m_wait > 0) || (MemReqM && !MemReadyM);
      if (m_err) begin
        me = 1; sf = 1; sd = 1; se = 1; sm = 1;
      end else if (frz) begin
        sf = 1; sd = 1; se = 1; sm = 1; fw = 1;
      end else begin
        sf = ld; sd = ld;
        fd = BranchTakenE;
        fe = BranchTakenE || ld;
      end
    end
    chk("ForwardAE", ForwardAE, fa);
    chk("ForwardBE", ForwardBE, fb);
    chk("StallF", StallF, sf);
    chk("StallD", StallD, sd);
    chk("StallE", StallE, se);
    chk("StallM", StallM, sm);
    chk("FlushD", FlushD, fd);
    chk("FlushE", FlushE, fe);
    chk("FlushW", FlushW, fw);
    chk("MemErr", MemErr, me);
    chk("StallCnt", StallCnt, m_sc);
    chk("FlushCnt", FlushCnt, m_fc);
    if (rst) begin
      m_wait = 0; m_err = 0; m_sc = 0; m_fc = 0;
    end else begin
      if (sf || sd || se || sm) m_sc = (m_sc < CMAX) ? m_sc + 1 : CMAX;
      if (fd || fe) m_fc = (m_fc < CMAX) ? m_fc + 1 : CMAX;
      if (!m_err) begin
        if (m_wait == 0) begin
          if (MemReqM && !MemReadyM) m_wait = 1;
        end else if (MemReadyM) begin
          m_wait = 0;
        end else if (m_wait == TMO) begin
          m_wait = 0;
          m_err = 1;
        end else begin
          m_wait++;
        end
      end
    end
  end

  function automatic logic [RW-1:0] rreg();
    if ($urandom_range(0, 7) == 0) return RW'(15);
    return RW'($urandom_range(0, 6));
  endfunction

  initial begin
    clear_in();
    rst = 1;
    RA1E = 3; WA3M = 3; RegWriteM = 1;
    MemtoRegE = 1; RegWriteE = 1; WA3E = 5; RA2D = 5;
    BranchTakenE = 1;
    @(negedge clk);
    chk("rst_fwd", ForwardAE, 0);
    chk("rst_stallF", StallF, 0);
    chk("rst_flushE", FlushE, 0);
    nxt();
    clear_in();
    rst = 0;

    RA1E = 3; WA3M = 3; RegWriteM = 1; WA3W = 3; RegWriteW = 1;
    @(negedge clk);
    chk("fwd_mem", ForwardAE, 2);
    nxt();
    RegWriteM = 0;
    @(negedge clk);
    chk("fwd_wb", ForwardAE, 1);
    nxt();
    RA1E = 15; WA3M = 15; WA3W = 15; RegWriteM = 1;
    @(negedge clk);
    chk("fwd_pc", ForwardAE, 0);
    nxt();
    clear_in();

    MemtoRegE = 1; RegWriteE = 1; WA3E = 5; RA2D = 5;
    @(negedge clk);
    chk("lu_stallF", StallF, 1);
    chk("lu_stallD", StallD, 1);
    chk("lu_flushE", FlushE, 1);
    chk("lu_fcnt0", FlushCnt, 0);
    nxt();
    clear_in();
    @(negedge clk);
    chk("lu_fcnt1", FlushCnt, 1);
    chk("lu_release", StallF, 0);

    nxt();
    MemtoRegE = 1; RegWriteE = 1; WA3E = 5; RA1D = 5;
    BranchTakenE = 1;
    @(negedge clk);
    chk("br_flushD", FlushD, 1);
    chk("br_flushE", FlushE, 1);
    chk("br_stallF", StallF, 1);
    chk("br_stallD", StallD, 1);
    nxt();
    clear_in();
    @(negedge clk);
    chk("br_fcnt", FlushCnt, 2);
    chk("br_scnt", StallCnt, 2);

    nxt();
    rst = 1;
    nxt();
    rst = 0;
    @(negedge clk);
    chk("rst_scnt", StallCnt, 0);

    nxt();
    MemReqM = 1;
    @(negedge clk);
    chk("mw_stallM", StallM, 1);
    chk("mw_flushW", FlushW, 1);
    nxt();
    MemReqM = 0;
    BranchTakenE = 1;
    @(negedge clk);
    chk("mw_br_flushD", FlushD, 0);
    chk("mw_stallE", StallE, 1);
    nxt();
    nxt();
    MemReadyM = 1;
    @(negedge clk);
    chk("mw_ready_stall", StallF, 1);
    nxt();
    MemReadyM = 0;
    @(negedge clk);
    chk("mw_rel_flushD", FlushD, 1);
    chk("mw_rel_stallF", StallF, 0);
    chk("mw_scnt", StallCnt, 4);
    nxt();
    clear_in();

    MemReqM = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 4) chk("tmo_pre", MemErr, 0);
      if (i == 5) chk("tmo_err", MemErr, 1);
      nxt();
    end
    MemReqM = 0;
    BranchTakenE = 1;
    repeat (20) nxt();
    @(negedge clk);
    chk("err_sticky", MemErr, 1);
    chk("err_noflush", FlushD, 0);
    chk("err_stall", StallF, 1);
    chk("err_sat", StallCnt, 15);
    nxt();
    clear_in();
    rst = 1;
    nxt();
    rst = 0;
    @(negedge clk);
    chk("err_clr", MemErr, 0);
    chk("err_clr_cnt", StallCnt, 0);
    chk("err_clr_stall", StallF, 0);

    for (int c = 0; c < 3000; c++) begin
      nxt();
      rst = ($urandom_range(0, 149) == 0);
      RA1D = rreg(); RA2D = rreg();
      RA1E = rreg(); RA2E = rreg();
      WA3E = rreg(); WA3M = rreg(); WA3W = rreg();
      RegWriteE = $urandom_range(0, 1);
      RegWriteM = $urandom_range(0, 1);
      RegWriteW = $urandom_range(0, 1);
      MemtoRegE = ($urandom_range(0, 9) < 3);
      BranchTakenE = ($urandom_range(0, 9) < 2);
      MemReqM = ($urandom_range(0, 9) < 3);
      MemReadyM = ($urandom_range(0, 9) < 6);
    end
    nxt();
    clear_in();
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
